// File: rtl/no_samples_in.sv
// Input-side sample counter for the FFT. It accepts one frame of NUM_SAMPLES samples over
// valid/ready, writes each sample into the input buffer, and holds input_done until frame_ack.
module no_samples_in #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_SAMPLES  = 32,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_ena,
  input  logic                     fft_busy,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample_data,
  output logic                     sample_ready,
  output logic                     wr_en,
  output logic [COUNT_WIDTH-2:0]   wr_addr,
  output logic [SAMPLE_WIDTH-1:0]  wr_data,
  output logic                     input_strobe,
  output logic [COUNT_WIDTH-1:0]   samples_in_count_out,
  output logic                     input_done,
  input  logic                     frame_ack,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(NUM_SAMPLES);

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   accept;

  assign count_inc            = count + COUNT_WIDTH'(1);
  assign sample_ready         = (state == LOAD) && input_ena && !fft_busy;
  assign accept               = sample_valid && sample_ready;
  assign input_done           = (state == FULL);
  assign samples_in_count_out = count;

  // NOTE: non-blocking (<=) for every register so all flops update together at the edge;
  // blocking assignments here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (input_ena) state_next = LOAD;
      end
      LOAD: begin
        // The accept that fills the frame moves to FULL on the same edge.
        if (accept && (count_inc == FULL_COUNT)) state_next = FULL;
      end
      FULL: begin
        if (frame_ack) state_next = input_ena ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      input_strobe <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      wr_en        <= accept;
      input_strobe <= accept;
      if (accept) begin
        wr_addr <= count[COUNT_WIDTH-2:0];
        wr_data <= sample_data;
        count   <= count_inc;
      end
      if (state == FULL) begin
        // An acknowledge takes priority over a simultaneous late sample.
        if (frame_ack) begin
          count   <= '0;
          overrun <= 1'b0;
        end else if (sample_valid) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_no_samples_in.sv
// Self-checking bench for no_samples_in: a directed vector table followed by
// hand-written multi-cycle sequences for frame fill, pausing, overrun, stalls and reset.
module tb_no_samples_in;

  logic        clk = 1'b0;
  logic        reset, input_ena, fft_busy, sample_valid, frame_ack;
  logic [15:0] sample_data;
  logic        sample_ready, wr_en, input_strobe, input_done, overrun;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  samples_in_count_out;

  int checks   = 0;
  int failures = 0;

  no_samples_in #(.SAMPLE_WIDTH(16), .NUM_SAMPLES(32), .COUNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .input_ena(input_ena), .fft_busy(fft_busy),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .input_strobe(input_strobe),
    .samples_in_count_out(samples_in_count_out), .input_done(input_done),
    .frame_ack(frame_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ena, busy, valid, ack;
    logic [15:0] data;
    logic        rdy;
    logic        wr_en;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        strobe;
    logic [5:0]  cnt;
    logic        done, ovr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ena, busy, valid, ack, input logic [15:0] data);
    reset = rst; input_ena = ena; fft_busy = busy;
    sample_valid = valid; frame_ack = ack; sample_data = data;
  endtask

  // Lets combinational outputs settle on the current inputs, then checks sample_ready.
  task automatic check_ready(input string name, input logic exp);
    #1;
    check({name, ".ready"}, 32'(sample_ready), 32'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic en, input logic [4:0] addr,
                            input logic [15:0] wdata, input logic strobe, input logic [5:0] cnt,
                            input logic done, input logic ovr);
    check({name, ".wr_en"},  32'(wr_en), 32'(en));
    check({name, ".wr_addr"}, 32'(wr_addr), 32'(addr));
    check({name, ".wr_data"}, 32'(wr_data), 32'(wdata));
    check({name, ".strobe"}, 32'(input_strobe), 32'(strobe));
    check({name, ".count"},  32'(samples_in_count_out), 32'(cnt));
    check({name, ".done"},   32'(input_done), 32'(done));
    check({name, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    vecs[0] = '{0,0,0,1,0,16'h1111, 0, 0,5'd0,16'h0000,0,6'd0,0,0};
    vecs[1] = '{0,1,0,1,0,16'h2222, 0, 0,5'd0,16'h0000,0,6'd0,0,0};
    vecs[2] = '{0,1,0,1,0,16'h3333, 1, 1,5'd0,16'h3333,1,6'd1,0,0};
    vecs[3] = '{0,1,1,1,0,16'h4444, 0, 0,5'd0,16'h3333,0,6'd1,0,0};
    vecs[4] = '{0,0,0,1,0,16'h5555, 0, 0,5'd0,16'h3333,0,6'd1,0,0};
    vecs[5] = '{0,1,0,0,1,16'h6666, 1, 0,5'd0,16'h3333,0,6'd1,0,0};
    vecs[6] = '{0,1,0,1,0,16'h7777, 1, 1,5'd1,16'h7777,1,6'd2,0,0};
    vecs[7] = '{1,1,0,1,0,16'h8888, 1, 0,5'd0,16'h0000,0,6'd0,0,0};
    vecs[8] = '{0,0,0,0,0,16'h9999, 0, 0,5'd0,16'h0000,0,6'd0,0,0};

    drive(0, 0, 0, 0, 0, 16'h0);
    cyc();

    // Reset state
    do_reset();
    check_ready("reset", 1'b0);
    check_outs("reset", 0, 5'd0, 16'h0, 0, 6'd0, 0, 0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].ena, vecs[i].busy, vecs[i].valid, vecs[i].ack, vecs[i].data);
      check_ready($sformatf("vec%0d", i), vecs[i].rdy);
      cyc();
      check_outs($sformatf("vec%0d", i), vecs[i].wr_en, vecs[i].addr, vecs[i].wdata,
                 vecs[i].strobe, vecs[i].cnt, vecs[i].done, vecs[i].ovr);
    end

    // Full frame on consecutive cycles, then overrun and acknowledge
    do_reset();
    drive(0, 1, 0, 1, 0, 16'h0100);
    cyc();
    for (int i = 0; i < 32; i++) begin
      sample_data = 16'h0100 + 16'(i);
      check_ready($sformatf("fill%0d", i), 1'b1);
      cyc();
      check_outs($sformatf("fill%0d", i), 1, 5'(i), 16'h0100 + 16'(i), 1, 6'(i + 1), i == 31, 0);
    end
    for (int i = 0; i < 3; i++) begin
      check_ready($sformatf("ovr%0d", i), 1'b0);
      cyc();
      check_outs($sformatf("ovr%0d", i), 0, 5'd31, 16'h011F, 0, 6'd32, 1, 1);
    end
    drive(0, 1, 0, 0, 1, 16'h0);
    cyc();
    check_outs("ack", 0, 5'd31, 16'h011F, 0, 6'd0, 0, 0);
    drive(0, 1, 0, 1, 0, 16'hBEEF);
    check_ready("after_ack", 1'b1);
    cyc();
    check_outs("after_ack", 1, 5'd0, 16'hBEEF, 1, 6'd1, 0, 0);

    // Enable toggling every cycle: one accept per enabled cycle
    do_reset();
    drive(0, 1, 0, 1, 0, 16'h0);
    cyc();
    for (int k = 0; k < 64; k++) begin
      input_ena = k[0];
      sample_data = 16'h2000 + 16'(k / 2);
      check_ready($sformatf("alt%0d", k), k[0]);
      cyc();
      check($sformatf("alt%0d.wr_en", k), 32'(wr_en), 32'(k[0]));
      check($sformatf("alt%0d.count", k), 32'(samples_in_count_out), 32'((k + 1) / 2));
      check($sformatf("alt%0d.done", k), 32'(input_done), 32'(k == 63));
      if (k[0]) begin
        check($sformatf("alt%0d.addr", k), 32'(wr_addr), 32'(k / 2));
        check($sformatf("alt%0d.data", k), 32'(wr_data), 32'(16'h2000 + 16'(k / 2)));
      end
    end

    // fft_busy stall after 10 accepts
    do_reset();
    drive(0, 1, 0, 1, 0, 16'h0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      sample_data = 16'h0A00 + 16'(i);
      cyc();
    end
    check("busy.pre_count", 32'(samples_in_count_out), 32'd10);
    fft_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_ready($sformatf("busy%0d", i), 1'b0);
      cyc();
      check($sformatf("busy%0d.count", i), 32'(samples_in_count_out), 32'd10);
      check($sformatf("busy%0d.wr_en", i), 32'(wr_en), 32'd0);
    end
    fft_busy = 1'b0;
    sample_data = 16'h0A0A;
    check_ready("resume", 1'b1);
    cyc();
    check_outs("resume", 1, 5'd10, 16'h0A0A, 1, 6'd11, 0, 0);

    // Reset mid-frame at count 17
    for (int i = 11; i < 17; i++) begin
      sample_data = 16'h0A00 + 16'(i);
      cyc();
    end
    check("mid.count", 32'(samples_in_count_out), 32'd17);
    drive(1, 1, 0, 1, 0, 16'hDEAD);
    cyc();
    reset = 1'b0;
    check_ready("mid_reset", 1'b0);
    check_outs("mid_reset", 0, 5'd0, 16'h0, 0, 6'd0, 0, 0);
    sample_data = 16'hCAFE;
    cyc();
    check_ready("reload", 1'b1);
    cyc();
    check_outs("reload", 1, 5'd0, 16'hCAFE, 1, 6'd1, 0, 0);

    // Acknowledge and late sample on the same edge: ack wins
    do_reset();
    drive(0, 1, 0, 1, 0, 16'h3000);
    cyc();
    for (int i = 0; i < 32; i++) begin
      sample_data = 16'h3000 + 16'(i);
      cyc();
    end
    check("tie.pre_done", 32'(input_done), 32'd1);
    check("tie.pre_overrun", 32'(overrun), 32'd0);
    drive(0, 0, 0, 1, 1, 16'h3FFF);
    cyc();
    drive(0, 0, 0, 0, 0, 16'h0);
    check_ready("tie", 1'b0);
    check_outs("tie", 0, 5'd31, 16'h301F, 0, 6'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/no_samples_in.md
Name: no_samples_in

Overview:
- Input-side counterpart of the FFT's output sample counter.
- Accepts a frame of NUM_SAMPLES time-domain samples from the upstream source over a valid/ready handshake.
- Writes each sample into the FFT input buffer with a registered address/data/enable, and publishes a running sample count.
- Holds `input_done` once the frame is full, until the FFT core acknowledges it with `frame_ack`.

Parameters:
- SAMPLE_WIDTH, 16, bit width of one input sample (real part only).
- NUM_SAMPLES, 32, samples per FFT frame; must be a power of two, 2 to 32.
- COUNT_WIDTH, 6, width of the sample counter; must satisfy 2^COUNT_WIDTH > NUM_SAMPLES.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- input_ena  input  1  level enable; frame loading proceeds only while high.
- fft_busy  input  1  FFT core is reading the input buffer; stalls acceptance.
- sample_valid  input  1  upstream sample present on sample_data.
- sample_data  input  SAMPLE_WIDTH  upstream sample.
- sample_ready  output  1  block accepts sample_data this cycle.
- wr_en  output  1  input-buffer write strobe.
- wr_addr  output  COUNT_WIDTH-1  input-buffer write address.
- wr_data  output  SAMPLE_WIDTH  input-buffer write data.
- input_strobe  output  1  one-cycle pulse per accepted sample.
- samples_in_count_out  output  COUNT_WIDTH  samples accepted in the current frame (0..NUM_SAMPLES).
- input_done  output  1  frame complete, waiting for acknowledge.
- frame_ack  input  1  FFT core has taken the frame.
- overrun  output  1  sticky flag: sample_valid asserted while the frame is full.

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - State goes to IDLE.
  - count = 0.
  - wr_en, wr_addr, wr_data, input_strobe, overrun all go to 0.
  - sample_ready and input_done are 0 from the cycle after reset.
  - A reset mid-frame discards the partial frame; no further writes occur.
- FSM states: IDLE, LOAD, FULL (state register is the only source of input_done).
  - IDLE: sample_ready=0. input_ena=1 at a clock edge moves to LOAD.
  - LOAD: sample_ready = input_ena & ~fft_busy (combinational from state and inputs).
  - LOAD, pausing: input_ena=0 stalls the frame; state and count are held and the frame is not aborted.
  - LOAD, accept: an accept is sample_valid & sample_ready at a rising edge. At that same edge:
    - wr_en<=1, wr_addr<=count[COUNT_WIDTH-2:0], wr_data<=sample_data.
    - input_strobe<=1.
    - count<=count+1.
    - All four registered outputs are high/valid for exactly the following cycle (1-cycle latency); otherwise wr_en<=0 and input_strobe<=0.
  - LOAD to FULL: the accept that makes count reach NUM_SAMPLES also moves the state to FULL at that edge. sample_ready is 0 in the next cycle, so no (NUM_SAMPLES+1)th sample is ever accepted.
  - FULL:
    - input_done=1, sample_ready=0, count holds at NUM_SAMPLES.
    - frame_ack=1 at an edge: count<=0, overrun<=0, state<=LOAD if input_ena=1, else IDLE. Back-to-back frames lose no cycle beyond the ack cycle.
    - sample_valid=1 at an edge (no ack in same cycle): overrun<=1, held until frame_ack or reset.
    - frame_ack and sample_valid in the same cycle: ack wins; overrun is cleared, not set.
- frame_ack in IDLE or LOAD is ignored.
- fft_busy only gates sample_ready; it does not change state.
- wr_addr wraps naturally: the NUM_SAMPLES accepts of a frame cover 0..NUM_SAMPLES-1 exactly once each, in order.
- samples_in_count_out is the count register directly (registered, no combinational path from inputs).

Test Plan:
1. Reset, then input_ena=1, sample_valid=1 continuously with sample_data = 0x0100+i:
   - 32 accepts on consecutive cycles; wr_addr 0..31 with matching data, one cycle after each accept.
   - Count reaches 32 and input_done=1 the cycle after the 32nd accept; sample_ready=0 from then.
2. Alternate input_ena 0/1 every cycle with sample_valid=1:
   - Exactly one accept per enabled cycle; count advances by 1 per two cycles.
   - input_done after 64 cycles; no addresses skipped or repeated.
3. Full frame, hold sample_valid=1 for 3 cycles, then pulse frame_ack with input_ena=1:
   - overrun=1 until the ack edge, then 0.
   - Count goes to 0 and state to LOAD; the next sample is written to wr_addr 0.
4. fft_busy=1 during accepts 10..14 of a frame:
   - sample_ready=0 and count stays at 10 throughout; resumes at 10 after fft_busy drops.
5. Assert reset when count=17:
   - Next cycle: count=0, wr_en=0, sample_ready=0, input_done=0, overrun=0, state IDLE.
   - Re-enabled loading starts at wr_addr 0.
6. In FULL, frame_ack and sample_valid both 1 on the same edge:
   - overrun stays 0; count=0; input_done drops the following cycle.
